// File: rtl/game_round_controller.sv
// game_round_controller: memory-game round sequencer (sequence generation, level/lives/score, RAM port ownership)
module game_round_controller #(
   parameter int         MAX_LVL  = 5,
   parameter int         NUM_SYM  = 4,
   parameter int         LIVES    = 3,
   parameter logic [27:0] TIMEOUT = 28'd250000000,
   parameter logic [4:0] SEQ_ADDR = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        disp_done,
   input  logic        chk_correct,
   input  logic        chk_incorrect,
   input  logic        chk_ram_r,
   input  logic [4:0]  chk_ram_addr,
   output logic        ram_we,
   output logic        ram_re,
   output logic [4:0]  ram_addr,
   output logic [19:0] ram_wdata,
   output logic        disp_start,
   output logic        chk_go,
   output logic        chk_rst_n,
   output logic [2:0]  lvl,
   output logic [1:0]  lives_left,
   output logic [7:0]  score,
   output logic        won,
   output logic        lost
);
   typedef enum logic [3:0] {IDLE, GEN, WRITE, SHOW, WAIT_DISP, ARM, PLAY, LVL_UP, MISS, WIN, LOSE} state_t;
   state_t      state;
   logic [15:0] lfsr;
   logic [2:0]  idx;
   logic [27:0] cnt;
   // the RAM port belongs to the checker except during the single write cycle
   assign ram_re   = chk_ram_r & ~ram_we;
   assign ram_addr = ram_we ? SEQ_ADDR : chk_ram_addr;
   // free-running Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk)
      lfsr <= !rst ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   // round FSM; strobes are set on entry to the state they belong to so they are registered
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         ram_we     <= 1'b0;
         ram_wdata  <= '0;
         disp_start <= 1'b0;
         chk_go     <= 1'b0;
         chk_rst_n  <= 1'b1;
         lvl        <= '0;
         lives_left <= '0;
         score      <= '0;
         won        <= 1'b0;
         lost       <= 1'b0;
         idx        <= '0;
         cnt        <= '0;
      end else begin
         ram_we     <= 1'b0;
         disp_start <= 1'b0;
         chk_go     <= 1'b0;
         chk_rst_n  <= 1'b1;
         case (state)
            IDLE, WIN, LOSE: if (start) begin
               state      <= GEN;
               won        <= 1'b0;
               lost       <= 1'b0;
               score      <= '0;
               lvl        <= 3'd1;
               lives_left <= 2'(LIVES);
               idx        <= '0;
            end
            GEN: if (lfsr[3:0] < 4'(NUM_SYM)) begin
               ram_wdata <= {ram_wdata[15:0], lfsr[3:0]};
               idx       <= idx + 3'd1;
               if (idx == 3'd4) begin
                  state  <= WRITE;
                  ram_we <= 1'b1;
               end
            end
            WRITE: begin
               state      <= SHOW;
               disp_start <= 1'b1;
            end
            SHOW: state <= WAIT_DISP;
            WAIT_DISP: if (disp_done) begin
               state  <= ARM;
               chk_go <= 1'b1;
            end
            ARM: begin
               cnt   <= '0;
               state <= PLAY;
            end
            PLAY: begin
               cnt <= cnt + 28'd1;
               if (chk_incorrect) state <= MISS;
               else if (cnt == TIMEOUT - 28'd1) begin
                  state     <= MISS;
                  chk_rst_n <= 1'b0;
               end else if (chk_correct) state <= LVL_UP;
            end
            LVL_UP: begin
               score <= (score == 8'hff) ? score : score + 8'd1;
               if (lvl == 3'(MAX_LVL)) begin
                  state <= WIN;
                  won   <= 1'b1;
               end else begin
                  lvl        <= lvl + 3'd1;
                  state      <= SHOW;
                  disp_start <= 1'b1;
               end
            end
            MISS: begin
               lives_left <= lives_left - 2'(lives_left != 2'd0);
               if (lives_left <= 2'd1) begin
                  state <= LOSE;
                  lost  <= 1'b1;
               end else begin
                  state      <= SHOW;
                  disp_start <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: scoreboard bench for the round sequencer
module tb_game_round_controller;
   logic        clk = 0, rst = 0, start = 0, disp_done = 0, chk_correct = 0, chk_incorrect = 0, chk_ram_r = 0;
   logic [4:0]  chk_ram_addr = 0;
   logic        ram_we, ram_re, disp_start, chk_go, chk_rst_n, won, lost;
   logic [4:0]  ram_addr;
   logic [19:0] ram_wdata;
   logic [2:0]  lvl;
   logic [1:0]  lives_left;
   logic [7:0]  score;
   typedef struct {int lvl; int lives; int score;} exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0, errors = 0, writes = 0, rst_lows = 0;
   int m_lvl, m_lives, m_score, m_won, m_lost;

   game_round_controller #(.TIMEOUT(28'd16)) dut (
      .clk(clk), .rst(rst), .start(start), .disp_done(disp_done),
      .chk_correct(chk_correct), .chk_incorrect(chk_incorrect),
      .chk_ram_r(chk_ram_r), .chk_ram_addr(chk_ram_addr),
      .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .disp_start(disp_start), .chk_go(chk_go), .chk_rst_n(chk_rst_n),
      .lvl(lvl), .lives_left(lives_left), .score(score), .won(won), .lost(lost));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // scoreboard consumer: every disp_start must match the next queued expectation
   always @(negedge clk) if (rst) begin
      if (disp_start) begin
         if (q.size() == 0) check("unexp_disp", 1, 0);
         else begin
            e = q.pop_front();
            check("disp_lvl", lvl, e.lvl);
            check("disp_lives", lives_left, e.lives);
            check("disp_score", score, e.score);
         end
      end
      if (ram_we) begin
         writes++;
         check("we_addr", ram_addr, 0);
         check("we_re", ram_re, 0);
         for (int k = 0; k < 5; k++) check("nibble", ram_wdata[k*4 +: 4] < 4, 1);
      end
      if (!chk_rst_n) rst_lows++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp();
      q.push_back('{m_lvl, m_lives, m_score});
   endtask

   task automatic press_start();
      cyc(1);
      m_lvl = 1; m_lives = 3; m_score = 0; m_won = 0; m_lost = 0;
      push_exp();
      chk_ram_r = 1; chk_ram_addr = 5'd31;
      start = 1;
      cyc(1);
      start = 0;
   endtask

   task automatic wait_disp();
      int i;
      for (i = 0; i < 300; i++) begin
         @(negedge clk);
         if (disp_start) break;
      end
      check("disp_seen", i < 300, 1);
   endtask

   task automatic check_game(input string tag);
      cyc(5);
      check({tag, "_won"}, won, m_won);
      check({tag, "_lost"}, lost, m_lost);
      check({tag, "_lvl"}, lvl, m_lvl);
      check({tag, "_lives"}, lives_left, m_lives);
      check({tag, "_score"}, score, m_score);
   endtask

   // v: 0 correct, 1 incorrect (plus stray start), 2 both verdicts, 3 no verdict (timeout)
   task automatic turn(input int v);
      int i;
      wait_disp();
      cyc(1);
      disp_done = 1;
      cyc(1);
      disp_done = 0;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (chk_go) break;
      end
      check("go_seen", i < 50, 1);
      cyc(1);
      chk_ram_addr = 5'($urandom);
      chk_ram_r = 1;
      #1;
      check("re_pass", ram_re, 1);
      check("addr_pass", ram_addr, chk_ram_addr);
      if (v == 0) begin
         m_score++;
         if (m_lvl == 5) m_won = 1;
         else begin m_lvl++; push_exp(); end
      end else begin
         m_lives--;
         if (m_lives == 0) m_lost = 1;
         else push_exp();
      end
      if (v == 3) begin
         for (i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!chk_rst_n) break;
         end
         check("timeout_cycles", i, 17);
         cyc(1);
      end else begin
         chk_correct = (v != 1);
         chk_incorrect = (v != 0);
         start = (v == 1);
         cyc(1);
         chk_correct = 0; chk_incorrect = 0; start = 0;
      end
      chk_ram_r = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(3);
      check("rst_we", ram_we, 0);
      check("rst_re", ram_re, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_disp", disp_start, 0);
      check("rst_go", chk_go, 0);
      check("rst_chkrst", chk_rst_n, 1);
      check("rst_lvl", lvl, 0);
      check("rst_lives", lives_left, 0);
      check("rst_score", score, 0);
      check("rst_wonlost", {won, lost}, 0);
      rst = 1;
      press_start();
      for (int l = 0; l < 5; l++) turn(0);
      check_game("win");
      check("win_writes", writes, 1);
      check("win_queue", q.size(), 0);
      press_start();
      turn(0);
      turn(1);
      turn(3);
      check("chk_rst_pulses", rst_lows, 1);
      turn(2);
      check_game("lose");
      check("lose_writes", writes, 2);
      check("lose_queue", q.size(), 0);
      press_start();
      wait_disp();
      cyc(1);
      rst = 0;
      cyc(2);
      rst = 1;
      cyc(40);
      check("midrst_lvl", lvl, 0);
      check("midrst_writes", writes, 3);
      check("midrst_queue", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
